// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
// State encoding and counter sizing are kept here so every user agrees on them.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // The bit counter needs clog2(width) bits. A 2-bit word still needs one bit.
  function automatic int cnt_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parametrised PISO serializer. A word is loaded through a valid/ready handshake
// and then shifted out one bit per shift_en tick. Both LSB-first and MSB-first orders are supported.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter bit MSB_FIRST  = 1'b0,
  parameter bit FILL_BIT   = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] data_in,
  input  logic             shift_en,
  input  logic             abort,
  output logic             ser_out,
  output logic             busy,
  output logic             frame_done
);

  localparam int            CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  if (WIDTH < 2) begin : g_width_check
    $error("piso_serializer: WIDTH must be >= 2");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] shreg_shifted;
  logic             accept;

  // The output end is the bit that ser_out presents. The fill bit enters at the opposite end.
  if (MSB_FIRST) begin : g_msb_first
    assign shreg_shifted = {shreg_q[WIDTH-2:0], FILL_BIT};
  end else begin : g_lsb_first
    assign shreg_shifted = {FILL_BIT, shreg_q[WIDTH-1:1]};
  end

  assign load_ready = (state_q == IDLE) && !abort;
  assign accept     = load_valid && load_ready;

  // NOTE: every next-state signal gets its hold value first, so the case arms only
  // list the changes and no path can leave a signal unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = SHIFT;
          shreg_d = data_in;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        if (abort) begin
          // abort overrides shift_en, even on the last bit, and does not pulse frame_done.
          state_d = IDLE;
          shreg_d = {WIDTH{FILL_BIT}};
          cnt_d   = '0;
        end else if (shift_en) begin
          shreg_d = shreg_shifted;
          if (cnt_q == LAST_BIT) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments, so every flop samples the
  // pre-edge value of every other flop, whatever order the statements are in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= {WIDTH{FILL_BIT}};
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // ser_out depends only on flops, so the line driver sees no glitches from the inputs.
  assign busy       = (state_q == SHIFT);
  assign frame_done = done_q;
  assign ser_out    = (state_q == SHIFT)
                      ? (MSB_FIRST ? shreg_q[WIDTH-1] : shreg_q[0])
                      : IDLE_LEVEL;

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer. It drives two configurations against a frame-level model.
// Instance A is 4 bits, LSB-first, with fill 1 and idle level 1. Instance B is 8 bits, MSB-first, with fill 0 and idle level 0.
module tb_piso_serializer;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       a_lv = 1'b0, a_se = 1'b1, a_ab = 1'b0;
  logic [3:0] a_d  = '0;
  logic       a_lr, a_ser, a_busy, a_done;

  logic       b_lv = 1'b0, b_se = 1'b1, b_ab = 1'b0;
  logic [7:0] b_d  = '0;
  logic       b_lr, b_ser, b_busy, b_done;

  piso_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .FILL_BIT(1'b1), .IDLE_LEVEL(1'b1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .load_valid(a_lv), .load_ready(a_lr), .data_in(a_d),
    .shift_en(a_se), .abort(a_ab), .ser_out(a_ser), .busy(a_busy), .frame_done(a_done)
  );

  piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .FILL_BIT(1'b0), .IDLE_LEVEL(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .load_valid(b_lv), .load_ready(b_lr), .data_in(b_d),
    .shift_en(b_se), .abort(b_ab), .ser_out(b_ser), .busy(b_busy), .frame_done(b_done)
  );

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Frame-level model. It tracks which word is in flight, how many bits have gone out, and the done pulse.
  typedef struct {
    bit         active;
    logic [7:0] word;
    int         idx;
    bit         done;
  } model_t;

  model_t ma, mb;

  function automatic model_t step(model_t m, int w, bit lv, logic [7:0] d, bit se, bit ab);
    model_t n = m;
    n.done = 1'b0;
    if (!m.active) begin
      if (lv && !ab) begin
        n.active = 1'b1;
        n.word   = d;
        n.idx    = 0;
      end
    end else if (ab) begin
      n.active = 1'b0;
    end else if (se) begin
      if (m.idx == w - 1) begin
        n.active = 1'b0;
        n.done   = 1'b1;
      end else begin
        n.idx = m.idx + 1;
      end
    end
    return n;
  endfunction

  function automatic logic exp_ser(model_t m, int w, bit msb, bit idle);
    if (!m.active) return idle;
    return msb ? m.word[w-1-m.idx] : m.word[m.idx];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= '{active: 1'b0, word: 8'h00, idx: 0, done: 1'b0};
      mb <= '{active: 1'b0, word: 8'h00, idx: 0, done: 1'b0};
    end else begin
      ma <= step(ma, 4, a_lv, {4'h0, a_d}, a_se, a_ab);
      mb <= step(mb, 8, b_lv, b_d, b_se, b_ab);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("a_ser_out",    {7'd0, a_ser},  {7'd0, exp_ser(ma, 4, 1'b0, 1'b1)});
      check("a_busy",       {7'd0, a_busy}, {7'd0, ma.active});
      check("a_frame_done", {7'd0, a_done}, {7'd0, ma.done});
      check("a_load_ready", {7'd0, a_lr},   {7'd0, !ma.active && !a_ab});
      check("b_ser_out",    {7'd0, b_ser},  {7'd0, exp_ser(mb, 8, 1'b1, 1'b0)});
      check("b_busy",       {7'd0, b_busy}, {7'd0, mb.active});
      check("b_frame_done", {7'd0, b_done}, {7'd0, mb.done});
      check("b_load_ready", {7'd0, b_lr},   {7'd0, !mb.active && !b_ab});
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic [3:0] bits4;
  logic [7:0] bits8;
  logic [3:0] w3;
  int         nacc, last_c;

  initial begin
    // Reset is asynchronous, so the outputs take their reset values with no clock edge.
    #1;
    check("rst_a_ser",  {7'd0, a_ser},  8'd1);
    check("rst_a_busy", {7'd0, a_busy}, 8'd0);
    check("rst_a_done", {7'd0, a_done}, 8'd0);
    check("rst_b_ser",  {7'd0, b_ser},  8'd0);
    #16 rst_n = 1'b1;
    @(negedge clk);
    check("rst_a_ready", {7'd0, a_lr}, 8'd1);

    // 4'b1010 LSB-first appears as 0,1,0,1. frame_done follows, and then the line returns to idle.
    tick(); a_lv = 1'b1; a_d = 4'b1010;
    tick(); a_lv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bits4[i] = a_ser;
    end
    check("t1_bits", {4'd0, bits4}, 8'h0A);
    @(negedge clk);
    check("t1_done", {7'd0, a_done}, 8'd1);
    check("t1_idle", {7'd0, a_ser},  8'd1);

    // 8'hC3 MSB-first appears as 1,1,0,0,0,0,1,1.
    tick(); b_lv = 1'b1; b_d = 8'hC3;
    tick(); b_lv = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); bits8[7-i] = b_ser;
    end
    check("t2_bits", bits8, 8'hC3);
    @(negedge clk);
    check("t2_done", {7'd0, b_done}, 8'd1);

    // shift_en arrives every third clock, so each bit of 4'b0110 is held for three clocks.
    w3 = 4'b0110;
    tick(); a_se = 1'b0; a_lv = 1'b1; a_d = w3;
    tick(); a_lv = 1'b0;
    for (int c = 0; c < 12; c++) begin
      a_se = ((c % 3) == 2);
      @(negedge clk);
      check("t3_held_bit", {7'd0, a_ser},  {7'd0, w3[c/3]});
      check("t3_busy",     {7'd0, a_busy}, 8'd1);
      tick();
    end
    a_se = 1'b1;
    @(negedge clk);
    check("t3_done", {7'd0, a_done}, 8'd1);

    // With load_valid held high, a word is accepted only every WIDTH+1 clocks.
    tick(); a_lv = 1'b1; a_d = 4'h5;
    nacc = 0; last_c = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (a_lr) begin
        if (nacc > 0) check("t4_spacing", 8'(c - last_c), 8'd5);
        last_c = c;
        nacc++;
      end
      tick();
      a_d = (nacc % 2 == 1) ? 4'hA : 4'h5;
    end
    check("t4_accepts", 8'(nacc), 8'd4);
    a_lv = 1'b0;
    for (int c = 0; c < 6; c++) tick();

    // An abort after two bits drops the frame with no frame_done. It also blocks a load while idle.
    a_lv = 1'b1; a_d = 4'b1100;
    tick(); a_lv = 1'b0;
    tick(); tick();
    a_ab = 1'b1;
    tick();
    a_lv = 1'b1; a_d = 4'b0011;
    @(negedge clk);
    check("t5_busy",  {7'd0, a_busy}, 8'd0);
    check("t5_ser",   {7'd0, a_ser},  8'd1);
    check("t5_done",  {7'd0, a_done}, 8'd0);
    check("t5_ready", {7'd0, a_lr},   8'd0);
    tick();
    a_ab = 1'b0;
    @(negedge clk);
    check("t5_blocked", {7'd0, a_busy}, 8'd0);
    tick(); a_lv = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); bits4[i] = a_ser;
    end
    check("t5_reload_bits", {4'd0, bits4}, 8'h03);

    // Reset asserted between clock edges in the middle of a frame.
    tick(); tick(); a_lv = 1'b1; a_d = 4'b1001;
    tick(); a_lv = 1'b0;
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_busy", {7'd0, a_busy}, 8'd0);
    check("t6_ser",  {7'd0, a_ser},  8'd1);
    check("t6_done", {7'd0, a_done}, 8'd0);
    #10 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t6_no_done", {7'd0, a_done}, 8'd0);
    end

    // Randomized traffic on both instances, checked cycle by cycle against the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      a_lv = 1'($urandom_range(0, 1));
      a_d  = 4'($urandom);
      a_se = ($urandom_range(0, 3) != 0);
      a_ab = ($urandom_range(0, 24) == 0);
      b_lv = 1'($urandom_range(0, 1));
      b_d  = 8'($urandom);
      b_se = ($urandom_range(0, 2) != 0);
      b_ab = ($urandom_range(0, 39) == 0);
    end
    tick();
    a_lv = 1'b0; a_ab = 1'b0; a_se = 1'b1;
    b_lv = 1'b0; b_ab = 1'b0; b_se = 1'b1;
    repeat (12) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
Parametrised parallel-in/serial-out serializer, the successor to the team's fixed 4-bit PISO.
- Accepts a WIDTH-bit word through a valid/ready load handshake.
- Shifts the word out one bit per shift-enable pulse, LSB-first or MSB-first.
- Reports busy and frame-done status and supports a synchronous abort.
- Sits between a parallel data source (register or FIFO) and a serial line driver; shift_en comes from a baud or prescaler tick.

Parameters:
- WIDTH, 4, word width in bits; must be >= 2.
- MSB_FIRST, 0, 0 = bit 0 is sent first, 1 = bit WIDTH-1 is sent first.
- FILL_BIT, 1, value shifted into vacated register positions.
- IDLE_LEVEL, 1, level driven on ser_out when no frame is active.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- load_valid  input  1  data_in is valid.
- load_ready  output  1  block can accept a word this cycle.
- data_in  input  WIDTH  parallel word.
- shift_en  input  1  advance one bit (tick); tie high for one bit per clock.
- abort  input  1  synchronous abort of the current frame.
- ser_out  output  1  serial data.
- busy  output  1  frame in progress.
- frame_done  output  1  one-cycle pulse after the last bit of a completed frame.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, shift register = all FILL_BIT, bit counter = 0, ser_out = IDLE_LEVEL, busy = 0, frame_done = 0, load_ready = 1 once rst_n is released.
- States: IDLE and SHIFT. The bit counter width is clog2(WIDTH).
- load_ready = (state == IDLE) && !abort. load_ready is combinational from state and abort only; there is no path from load_valid.
- Accept: on a clock edge where load_valid && load_ready:
  - shift register <= data_in, counter <= 0, state <= SHIFT.
  - The first bit appears on ser_out the next cycle (1-cycle latency).
  - data_in is ignored at all other times.
- In SHIFT:
  - ser_out = shreg[0] when MSB_FIRST = 0, else shreg[WIDTH-1].
  - busy = 1.
- On each edge in SHIFT with shift_en = 1:
  - The register shifts toward the output end and FILL_BIT enters the opposite end.
  - counter increments.
  - When counter == WIDTH-1, the state instead goes to IDLE and frame_done = 1 for exactly the following cycle.
- shift_en = 0 in SHIFT: all state holds and ser_out is stable. Bit k is held from its presentation until the k-th shift_en pulse.
- shift_en in IDLE has no effect.
- In IDLE, ser_out = IDLE_LEVEL and busy = 0.
- Back-to-back frames: the next word can be accepted in the cycle after the return to IDLE. Minimum frame spacing is WIDTH+1 clocks with shift_en tied high.
- abort = 1 in SHIFT:
  - Next edge: state IDLE, register = all FILL_BIT, counter = 0, no frame_done pulse.
  - abort takes priority over shift_en, including on the last bit.
- abort = 1 in IDLE: no state change, and load is blocked that cycle because load_ready = 0.
- rst_n asserted mid-frame: immediate return to reset values, and frame_done does not pulse.
- frame_done and busy are registered outputs. ser_out is a mux of state and register, with no combinational path from inputs.

Decomposition:
- Package piso_pkg:
  - state enum {IDLE, SHIFT}.
  - Counter-width helper function (clog2-based).
- No sub-module is required. Counter, state, and shift register are one always block plus output assigns.
- An optional shared tick generator, piso_tick_gen (prescaler that produces shift_en), lives separately and is not part of this block.

Test Plan:
- Reset then load 4'b1010 (WIDTH=4, LSB-first, shift_en high):
  - ser_out = 0,1,0,1 on cycles 1-4 after acceptance.
  - frame_done pulses on cycle 5, then ser_out = 1.
- WIDTH=8, MSB_FIRST=1, load 8'hC3, shift_en high → ser_out = 1,1,0,0,0,0,1,1, then frame_done.
- load 4'b0110 with shift_en pulsed every 3rd clock → each bit is held 3 clocks, sequence 0,1,1,0, busy high throughout, frame_done after the 4th tick.
- Hold load_valid high continuously with alternating words 4'h5 / 4'hA:
  - load_ready is low during SHIFT, and words are accepted only in IDLE.
  - Each frame is 5 clocks apart, and no word is accepted mid-frame.
- abort after 2 bits of 4'b1100 → IDLE next cycle, ser_out = IDLE_LEVEL, no frame_done, then a new load of 4'b0011 serializes correctly.
- rst_n dropped asynchronously mid-frame (between clock edges) → outputs return to reset values immediately, busy = 0, no frame_done after release.
